// File: rtl/ram_b_master_pkg.sv
// Shared definitions for the RAM_B initiator: FSM state encoding, RAM
// geometry, the expected tag word and the read-pipe flag bundle.
package ram_b_master_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WR       = 2'd1,
      RD_ISSUE = 2'd2,
      RD_DRAIN = 2'd3
   } state_t;

   localparam logic [15:0] RAM_B_TAG    = 16'hFF37;
   localparam int          RAM_B_DEPTH  = 128;
   localparam int          RAM_B_ADDR_W = 20;
   localparam int          RAM_B_DATA_W = 32;

   // Per-beat sideband carried alongside the RAM read latency.
   typedef struct packed {
      logic valid;
      logic last;
      logic err;
   } rd_flags_t;

   // True when a word address falls outside the populated RAM range.
   function automatic logic addr_oob(input logic [RAM_B_ADDR_W-1:0] addr,
                                     input logic [RAM_B_ADDR_W-1:0] depth);
      return (addr >= depth);
   endfunction

endpackage

// File: rtl/ram_b_rd_pipe.sv
// Two-stage valid/last/err shift register. A beat enters when its address
// is driven onto addra and leaves two edges later, exactly when the RAM's
// registered read data for that address is on douta.
module ram_b_rd_pipe
   import ram_b_master_pkg::*;
(
   input  logic      i_clka,
   input  logic      i_rst,
   input  rd_flags_t i_flags,
   output rd_flags_t o_flags
);

   rd_flags_t r_stage [2];

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_stage
         if (gi == 0) begin : g_head
            // First stage samples the flags of the beat being issued.
            always_ff @(posedge i_clka or posedge i_rst) begin
               if (i_rst) r_stage[gi] <= '0;
               else       r_stage[gi] <= i_flags;
            end
         end else begin : g_tail
            // Later stages shift the flags forward one cycle.
            always_ff @(posedge i_clka or posedge i_rst) begin
               if (i_rst) r_stage[gi] <= '0;
               else       r_stage[gi] <= r_stage[gi-1];
            end
         end
      end
   endgenerate

   assign o_flags = r_stage[1];

endmodule

// File: rtl/ram_b_master.sv
// RAM_B initiator: single-word writes and burst reads over a valid/ready
// request port, driving a single-port RAM with a one-cycle registered read.
// Optional build macro: RAM_B_MASTER_TAG_CHECK_EN adds tag checking of
// douta[47:32] and the sticky tag_fault output.
module ram_b_master
   import ram_b_master_pkg::*;
#(
   parameter int          DEPTH = RAM_B_DEPTH,
   parameter int          LEN_W = 4,
   parameter logic [15:0] TAG   = RAM_B_TAG
)(
   input  logic                      clka,
   input  logic                      rst,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic                      req_we,
   input  logic [RAM_B_ADDR_W-1:0]   req_addr,
   input  logic [LEN_W-1:0]          req_len,
   input  logic [RAM_B_DATA_W-1:0]   req_wdata,
   output logic [RAM_B_ADDR_W-1:0]   addra,
   output logic                      wea,
   output logic [RAM_B_DATA_W-1:0]   dina,
   input  logic [RAM_B_DATA_W+15:0]  douta,
   output logic                      rsp_valid,
   output logic [RAM_B_DATA_W-1:0]   rsp_data,
   output logic                      rsp_last,
   output logic                      rsp_err,
   output logic                      wr_done
`ifdef RAM_B_MASTER_TAG_CHECK_EN
   ,
   output logic                      tag_fault
`endif
);

   localparam logic [RAM_B_ADDR_W-1:0] DEPTH_A = RAM_B_ADDR_W'(DEPTH);

   state_t                    r_state;
   logic [LEN_W-1:0]          r_remaining;
   logic                      w_accept;
   logic [RAM_B_ADDR_W-1:0]   w_next_addr;
   rd_flags_t                 w_issue;
   rd_flags_t                 w_pipe;
   logic                      w_tag_bad;

   assign req_ready   = (r_state == IDLE);
   assign w_accept    = req_valid & req_ready;
   assign w_next_addr = addra + RAM_B_ADDR_W'(1);

   // Flags for the beat whose address is loaded onto addra at this edge.
   always_comb begin
      w_issue = '0;
      if (r_state == IDLE && w_accept && !req_we) begin
         w_issue.valid = 1'b1;
         w_issue.last  = (req_len == '0);
         w_issue.err   = addr_oob(req_addr, DEPTH_A);
      end else if (r_state == RD_ISSUE && r_remaining != '0) begin
         w_issue.valid = 1'b1;
         w_issue.last  = (r_remaining == LEN_W'(1));
         w_issue.err   = addr_oob(w_next_addr, DEPTH_A);
      end
   end

   ram_b_rd_pipe u_rd_pipe (
      .i_clka  (clka),
      .i_rst   (rst),
      .i_flags (w_issue),
      .o_flags (w_pipe)
   );

   // Request FSM: owns the RAM port and the burst counter.
   always_ff @(posedge clka or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_remaining <= '0;
         addra       <= '0;
         wea         <= 1'b0;
         dina        <= '0;
         wr_done     <= 1'b0;
      end else begin
         wr_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  addra <= req_addr;
                  if (req_we) begin
                     dina    <= req_wdata;
                     wea     <= 1'b1;
                     r_state <= WR;
                  end else begin
                     r_remaining <= req_len;
                     r_state     <= RD_ISSUE;
                  end
               end
            end
            WR: begin
               // The RAM commits the word at this edge.
               wea     <= 1'b0;
               wr_done <= 1'b1;
               r_state <= IDLE;
            end
            RD_ISSUE: begin
               if (r_remaining != '0) begin
                  addra       <= w_next_addr;
                  r_remaining <= r_remaining - LEN_W'(1);
               end else begin
                  r_state <= RD_DRAIN;
               end
            end
            RD_DRAIN: begin
               // Release the port only once the final beat has been seen,
               // so a new request can never overlap an in-flight burst.
               if (rsp_last) r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

`ifdef RAM_B_MASTER_TAG_CHECK_EN
   assign w_tag_bad = w_pipe.valid && !w_pipe.err && (douta[RAM_B_DATA_W+15:RAM_B_DATA_W] != TAG);

   // Sticky record of any in-range beat that came back with a bad tag.
   always_ff @(posedge clka or posedge rst) begin
      if (rst)            tag_fault <= 1'b0;
      else if (w_tag_bad) tag_fault <= 1'b1;
   end
`else
   logic w_unused_tag;
   assign w_tag_bad    = 1'b0;
   assign w_unused_tag = ^{douta[RAM_B_DATA_W+15:RAM_B_DATA_W], TAG};
`endif

   // Response register: captures douta when the aligned flags say a beat
   // is due; data holds between beats, the flags pulse for one cycle.
   always_ff @(posedge clka or posedge rst) begin
      if (rst) begin
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         rsp_last  <= 1'b0;
         rsp_err   <= 1'b0;
      end else begin
         rsp_valid <= w_pipe.valid;
         rsp_last  <= w_pipe.valid & w_pipe.last;
         rsp_err   <= w_pipe.valid & (w_pipe.err | w_tag_bad);
         if (w_pipe.valid) rsp_data <= douta[RAM_B_DATA_W-1:0];
      end
   end

endmodule

// File: tb/tb_ram_b_master.sv
// Self-checking bench for ram_b_master with a behavioural RAM_B model.
// Build with +define+RAM_B_MASTER_TAG_CHECK_EN to exercise tag checking.
module tb_ram_b_master;

   logic         clka = 1'b0;
   logic         rst;
   logic         req_valid;
   logic         req_ready;
   logic         req_we;
   logic [19:0]  req_addr;
   logic [3:0]   req_len;
   logic [31:0]  req_wdata;
   logic [19:0]  addra;
   logic         wea;
   logic [31:0]  dina;
   logic [47:0]  douta;
   logic         rsp_valid;
   logic [31:0]  rsp_data;
   logic         rsp_last;
   logic         rsp_err;
   logic         wr_done;
`ifdef RAM_B_MASTER_TAG_CHECK_EN
   logic         tag_fault;
`endif

   always #5 clka = ~clka;

   ram_b_master dut (
      .clka      (clka),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_len   (req_len),
      .req_wdata (req_wdata),
      .addra     (addra),
      .wea       (wea),
      .dina      (dina),
      .douta     (douta),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data),
      .rsp_last  (rsp_last),
      .rsp_err   (rsp_err),
      .wr_done   (wr_done)
`ifdef RAM_B_MASTER_TAG_CHECK_EN
      ,
      .tag_fault (tag_fault)
`endif
   );

   // RAM_B model: 128 words, registered read, 0 for out-of-range reads.
   // douta simply holds during writes (stands in for high-Z).
   logic [31:0] mem [0:127];
   logic        tag_bad = 1'b0;
   always @(posedge clka) begin
      if (wea) begin
         if (addra < 20'd128) mem[addra[6:0]] <= dina;
      end else begin
         douta <= (addra < 20'd128) ? {(tag_bad ? 16'h1234 : 16'hFF37), mem[addra[6:0]]} : 48'h0;
      end
   end

   typedef struct packed {
      logic [31:0] data;
      logic        last;
      logic        err;
   } beat_t;

   beat_t       sb[$];
   beat_t       mon_e;
   logic [31:0] exp_mem [0:127];
   int          errors = 0;
   int          checks = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard consumer: every beat the DUT emits is matched in order.
   always @(negedge clka) begin
      if (!rst && rsp_valid) begin
         $display("beat  data=%08h last=%0b err=%0b", rsp_data, rsp_last, rsp_err);
         if (sb.size() == 0) begin
            chk("unexpected_beat", {63'd0, rsp_valid}, 64'd0);
         end else begin
            mon_e = sb.pop_front();
            chk("beat_data", {32'd0, rsp_data}, {32'd0, mon_e.data});
            chk("beat_last", {63'd0, rsp_last}, {63'd0, mon_e.last});
            chk("beat_err",  {63'd0, rsp_err},  {63'd0, mon_e.err});
         end
      end
   end

   task automatic wait_ready();
      for (int i = 0; i < 50 && !req_ready; i++) @(negedge clka);
      chk("req_ready_wait", {63'd0, req_ready}, 64'd1);
   endtask

   task automatic do_write(input logic [19:0] addr, input logic [31:0] data);
      wait_ready();
      req_valid = 1'b1; req_we = 1'b1; req_addr = addr; req_wdata = data;
      @(posedge clka); #1;
      req_valid = 1'b0; req_we = 1'b0;
      @(negedge clka);
      chk("wr_wea",     {63'd0, wea},     64'd1);
      chk("wr_addra",   {44'd0, addra},   {44'd0, addr});
      chk("wr_dina",    {32'd0, dina},    {32'd0, data});
      chk("wr_done_lo", {63'd0, wr_done}, 64'd0);
      @(negedge clka);
      chk("wr_done_pulse", {63'd0, wr_done}, 64'd1);
      chk("wr_wea_off",    {63'd0, wea},     64'd0);
      @(negedge clka);
      chk("wr_done_single", {63'd0, wr_done}, 64'd0);
      if (addr < 20'd128) exp_mem[addr[6:0]] = data;
      $display("write addr=%05h data=%08h", addr, data);
   endtask

   task automatic do_read(input logic [19:0] addr, input logic [3:0] len, input logic tagerr);
      logic [19:0] a;
      beat_t       e;
      logic        done;
      logic        first;
      for (int i = 0; i <= int'(len); i++) begin
         a      = addr + 20'(i);
         e.data = (a < 20'd128) ? exp_mem[a[6:0]] : 32'h0;
         e.last = (i == int'(len));
         e.err  = (a >= 20'd128) || tagerr;
         sb.push_back(e);
      end
      wait_ready();
      req_valid = 1'b1; req_we = 1'b0; req_addr = addr; req_len = len;
      @(posedge clka); #1;
      req_valid = 1'b0;
      done  = 1'b0;
      first = 1'b1;
      for (int cyc = 0; cyc < 40 && !done; cyc++) begin
         @(negedge clka); #1;
         if (cyc <= int'(len)) chk("addra_seq", {44'd0, addra}, {44'd0, addr + 20'(cyc)});
         if (rsp_valid && first) begin
            chk("first_latency", 64'(cyc), 64'd2);
            first = 1'b0;
         end else if (!first) begin
            chk("beat_stream", {63'd0, rsp_valid}, 64'd1);
         end
         if (rsp_valid && rsp_last) begin
            chk("last_latency",      64'(cyc), 64'(int'(len) + 2));
            chk("ready_during_last", {63'd0, req_ready}, 64'd0);
            @(negedge clka); #1;
            chk("ready_after_last",  {63'd0, req_ready}, 64'd1);
            done = 1'b1;
         end
      end
      chk("read_done", {63'd0, done}, 64'd1);
      chk("sb_empty",  64'(sb.size()), 64'd0);
      $display("read  addr=%05h len=%0d done", addr, len);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_addra"},     {44'd0, addra},     64'd0);
      chk({tag, "_wea"},       {63'd0, wea},       64'd0);
      chk({tag, "_dina"},      {32'd0, dina},      64'd0);
      chk({tag, "_rsp_valid"}, {63'd0, rsp_valid}, 64'd0);
      chk({tag, "_rsp_data"},  {32'd0, rsp_data},  64'd0);
      chk({tag, "_rsp_last"},  {63'd0, rsp_last},  64'd0);
      chk({tag, "_rsp_err"},   {63'd0, rsp_err},   64'd0);
      chk({tag, "_wr_done"},   {63'd0, wr_done},   64'd0);
      chk({tag, "_req_ready"}, {63'd0, req_ready}, 64'd1);
   endtask

   initial begin
      int cnt;
      int seen;
      beat_t e;
      rst = 1'b1; req_valid = 1'b0; req_we = 1'b0;
      req_addr = '0; req_len = '0; req_wdata = '0;
      for (int i = 0; i < 128; i++) exp_mem[i] = 32'h0;
      #12;
      chk_reset_outputs("reset");
      @(negedge clka);
      rst = 1'b0;
      @(negedge clka);

      // Write then single read of the same word.
      do_write(20'd5, 32'hDEADBEEF);
      do_read(20'd5, 4'd0, 1'b0);

      // Preload words for the burst tests.
      for (int i = 10; i <= 17; i++) do_write(20'(i), 32'hA500_0000 + 32'(i));
      do_write(20'd126, 32'h1111_2222);
      do_write(20'd127, 32'h3333_4444);
      do_write(20'd0,   32'h0BAD_F00D);

      do_read(20'd10, 4'd3, 1'b0);       // in-range burst
      do_read(20'd126, 4'd3, 1'b0);      // crosses DEPTH
      do_read(20'hFFFFF, 4'd1, 1'b0);    // address wrap
      do_read(20'd11, 4'd15, 1'b0);      // maximum burst length

      // Reset in the middle of a len=7 burst, right as beat 2 is presented.
      for (int i = 0; i < 2; i++) begin
         e.data = exp_mem[10 + i];
         e.last = 1'b0;
         e.err  = 1'b0;
         sb.push_back(e);
      end
      wait_ready();
      req_valid = 1'b1; req_we = 1'b0; req_addr = 20'd10; req_len = 4'd7;
      @(posedge clka); #1;
      req_valid = 1'b0;
      cnt = 0;
      for (int cyc = 0; cyc < 20 && cnt < 2; cyc++) begin
         @(negedge clka); #1;
         if (rsp_valid) cnt++;
      end
      chk("rst_reached_beat2", 64'(cnt), 64'd2);
      rst = 1'b1;
      #1;
      chk_reset_outputs("midrst");
      @(posedge clka);
      @(negedge clka);
      rst = 1'b0;
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clka); #1;
         if (rsp_valid) seen++;
      end
      chk("no_beats_after_rst", 64'(seen), 64'd0);
      chk("ready_after_rst", {63'd0, req_ready}, 64'd1);
      sb.delete();
      $display("reset mid-burst done");
      do_read(20'd12, 4'd1, 1'b0);

`ifdef RAM_B_MASTER_TAG_CHECK_EN
      chk("tag_fault_init", {63'd0, tag_fault}, 64'd0);
      tag_bad = 1'b1;
      do_read(20'd5, 4'd0, 1'b1);
      tag_bad = 1'b0;
      chk("tag_fault_set", {63'd0, tag_fault}, 64'd1);
      do_read(20'd5, 4'd0, 1'b0);
      chk("tag_fault_sticky", {63'd0, tag_fault}, 64'd1);
      @(negedge clka);
      rst = 1'b1;
      #1;
      chk("tag_fault_rst", {63'd0, tag_fault}, 64'd0);
      @(negedge clka);
      rst = 1'b0;
      $display("tag check done");
`endif

      repeat (2) @(negedge clka);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Last-resort bound on total run time.
   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

endmodule
